// File: rtl/serial_subtractor_nbit.sv
// -----------------------------------------------------------------------------
// serial_subtractor_nbit
//
// Bit-serial subtractor. It computes (a - b - borrow_in) mod 2^NUM_BITS one bit
// per clock, starting at the LSB. It trades latency for area: one full-subtractor
// cell does all the work, and the operands live in shift registers.
//
// Handshake (valid/ready semantics, documented once here):
//   start is sampled only when the block can accept work, which is in IDLE or
//   DONE. busy is low in those states and acts as "ready". When start is high
//   in IDLE or DONE, the block captures a, b and borrow_in on that clock edge.
//   When start is high in SHIFT, the block ignores it: nothing is queued, and
//   the operand inputs may change freely while busy is high.
//   done pulses high for exactly one cycle, on the cycle after the result
//   registers (diff, underflow) update. busy and done are never high together.
//
// Ports:
//   clk        system clock, rising edge
//   n_rst      synchronous active-low reset
//   start      operation request
//   a, b       minuend / subtrahend, captured on accepted start
//   borrow_in  borrow into bit 0, captured on accepted start
//   busy       high while the bit-serial computation runs (SHIFT)
//   done       one-cycle pulse: diff/underflow just updated
//   diff       registered result, (a - b - borrow_in) mod 2^NUM_BITS
//   underflow  registered final borrow, 1 iff a < b + borrow_in (unsigned)
//   state_dbg  current FSM state encoding (IDLE=0, SHIFT=1, DONE=2)
// -----------------------------------------------------------------------------
module serial_subtractor_nbit #(
   parameter int NUM_BITS = 4
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                start,
   input  logic [NUM_BITS-1:0] a,
   input  logic [NUM_BITS-1:0] b,
   input  logic                borrow_in,
   output logic                busy,
   output logic                done,
   output logic [NUM_BITS-1:0] diff,
   output logic                underflow,
   output logic [1:0]          state_dbg
);

   // One extra counter bit, so the count never wraps inside an operation.
   localparam int CW = $clog2(NUM_BITS) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t              state;
   state_t              state_next;

   logic [NUM_BITS-1:0] a_sr;
   logic [NUM_BITS-1:0] b_sr;
   logic [NUM_BITS-1:0] res_sr;
   logic                br;
   logic [CW-1:0]       cnt;

   logic                load;
   logic                step;
   logic                finish;
   logic                last_bit;
   logic                bit_d;
   logic                br_next;
   logic [NUM_BITS-1:0] res_next;

   // Full-subtractor cell acting on the current LSBs of the operand registers.
   assign bit_d    = a_sr[0] ^ b_sr[0] ^ br;
   assign br_next  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
   // Each new difference bit enters at the MSB. After NUM_BITS steps, the first
   // bit (the LSB of the result) has reached position 0.
   assign res_next = {bit_d, res_sr[NUM_BITS-1:1]};
   assign last_bit = (cnt == CW'(NUM_BITS - 1));

   // Next-state and datapath enables.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      step       = 1'b0;
      finish     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            step = 1'b1;
            if (last_bit) begin
               finish     = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            if (start) begin
               load       = 1'b1;
               state_next = SHIFT;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State register and datapath.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state     <= IDLE;
         a_sr      <= '0;
         b_sr      <= '0;
         res_sr    <= '0;
         br        <= 1'b0;
         cnt       <= '0;
         diff      <= '0;
         underflow <= 1'b0;
      end else begin
         state <= state_next;
         if (load) begin
            a_sr   <= a;
            b_sr   <= b;
            br     <= borrow_in;
            res_sr <= '0;
            cnt    <= '0;
         end else if (step) begin
            a_sr   <= {1'b0, a_sr[NUM_BITS-1:1]};
            b_sr   <= {1'b0, b_sr[NUM_BITS-1:1]};
            br     <= br_next;
            res_sr <= res_next;
            cnt    <= cnt + CW'(1);
            // The visible result updates only on the edge that enters DONE.
            if (finish) begin
               diff      <= res_next;
               underflow <= br_next;
            end
         end
      end
   end

   assign busy      = (state == SHIFT);
   assign done      = (state == DONE);
   assign state_dbg = state;

endmodule

// File: tb/tb_serial_subtractor_nbit.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor_nbit
//
// Self-checking bench for serial_subtractor_nbit. It drives a NUM_BITS=4
// instance for most scenarios and a NUM_BITS=8 instance for the wide spot
// checks. Expected results come from plain integer arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_serial_subtractor_nbit;

   localparam int NB  = 4;
   localparam int NB8 = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic n_rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT (4-bit) ----------------
   logic          start;
   logic [NB-1:0] a, b;
   logic          borrow_in;
   logic          busy, done;
   logic [NB-1:0] diff;
   logic          underflow;
   logic [1:0]    state_dbg;

   serial_subtractor_nbit #(.NUM_BITS(NB)) dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .start     (start),
      .a         (a),
      .b         (b),
      .borrow_in (borrow_in),
      .busy      (busy),
      .done      (done),
      .diff      (diff),
      .underflow (underflow),
      .state_dbg (state_dbg)
   );

   // ---------------- DUT (8-bit) ----------------
   logic           start8;
   logic [NB8-1:0] a8, b8;
   logic           borrow_in8;
   logic           busy8, done8;
   logic [NB8-1:0] diff8;
   logic           underflow8;
   logic [1:0]     state_dbg8;

   serial_subtractor_nbit #(.NUM_BITS(NB8)) dut8 (
      .clk       (clk),
      .n_rst     (n_rst),
      .start     (start8),
      .a         (a8),
      .b         (b8),
      .borrow_in (borrow_in8),
      .busy      (busy8),
      .done      (done8),
      .diff      (diff8),
      .underflow (underflow8),
      .state_dbg (state_dbg8)
   );

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;
   logic [NB:0] exp_q[$];   // {underflow, diff}

   // Reference model: plain arithmetic.
   function automatic logic [NB:0] ref_sub(input int av, input int bv, input int bi);
      int r;
      r = av - bv - bi;
      return {logic'(av < bv + bi), NB'(r & ((1 << NB) - 1))};
   endfunction

   // ---------------- driver ----------------
   // Called #1 after an edge. It issues one operation and follows it to done.
   // lat counts edges from the accept edge to the edge where done appears.
   task automatic do_op(input int av, input int bv, input int bi,
                        output int lat, output int bcnt, output bit ovl,
                        output logic [NB-1:0] d, output logic u);
      a = NB'(av); b = NB'(bv); borrow_in = bi[0]; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = -1; bcnt = 0; ovl = 1'b0; d = '0; u = 1'b0;
      for (int c = 0; c <= NB + 6; c++) begin
         if (busy && done) ovl = 1'b1;
         if (busy) bcnt++;
         if (done) begin
            lat = c; d = diff; u = underflow;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic apply_reset();
      n_rst = 1'b0; start = 1'b0; start8 = 1'b0;
      a = '0; b = '0; borrow_in = 1'b0;
      a8 = '0; b8 = '0; borrow_in8 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_rst = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      apply_reset();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || underflow !== 1'b0) begin
         errors++;
         $display("FAIL reset: busy=%b done=%b diff=%h uf=%b required 0 0 0 0",
                  busy, done, diff, underflow);
      end
      checks++;
      if (busy8 !== 1'b0 || done8 !== 1'b0 || diff8 !== '0 || underflow8 !== 1'b0) begin
         errors++;
         $display("FAIL reset8: busy=%b done=%b diff=%h uf=%b required 0 0 0 0",
                  busy8, done8, diff8, underflow8);
      end
   endtask

   task automatic test_basic();
      int lat, bcnt; bit ovl; logic [NB-1:0] d; logic u;
      int tv[3][3] = '{'{7, 3, 0}, '{3, 7, 0}, '{0, 0, 1}};
      logic [NB:0] e;
      for (int i = 0; i < 3; i++) begin
         e = ref_sub(tv[i][0], tv[i][1], tv[i][2]);
         do_op(tv[i][0], tv[i][1], tv[i][2], lat, bcnt, ovl, d, u);
         checks++;
         if ({u, d} !== e) begin
            errors++;
            $display("FAIL basic_result[%0d]: got uf=%b diff=%h required uf=%b diff=%h",
                     i, u, d, e[NB], e[NB-1:0]);
         end
         checks++;
         if (lat != NB || bcnt != NB || ovl) begin
            errors++;
            $display("FAIL basic_timing[%0d]: latency=%0d busy_cycles=%0d overlap=%b required %0d %0d 0",
                     i, lat, bcnt, ovl, NB, NB);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      int lat, bcnt; bit ovl; logic [NB-1:0] d; logic u;
      int c_first;
      do_op(15, 15, 0, lat, bcnt, ovl, d, u);
      c_first = cyc;
      checks++;
      if ({u, d} !== ref_sub(15, 15, 0)) begin
         errors++;
         $display("FAIL b2b_first: got uf=%b diff=%h required uf=0 diff=0", u, d);
      end
      // Still in the DONE cycle: start is accepted at the next edge.
      do_op(9, 2, 1, lat, bcnt, ovl, d, u);
      checks++;
      if ({u, d} !== ref_sub(9, 2, 1)) begin
         errors++;
         $display("FAIL b2b_second: got uf=%b diff=%h required uf=0 diff=6", u, d);
      end
      checks++;
      if (lat != NB || cyc - c_first != NB + 1 || ovl) begin
         errors++;
         $display("FAIL b2b_spacing: latency=%0d done_gap=%0d overlap=%b required %0d %0d 0",
                  lat, cyc - c_first, ovl, NB, NB + 1);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_start_ignored();
      int ndone, lat; bit held_ok;
      logic [NB-1:0] d; logic u;
      apply_reset();
      a = 4'd12; b = 4'd5; borrow_in = 1'b0; start = 1'b1;
      @(posedge clk); #1;                 // accept edge
      start = 1'b0;
      @(posedge clk); #1;                 // second SHIFT cycle
      a = 4'd1; b = 4'd1; start = 1'b1;
      ndone = 0; lat = -1; held_ok = 1'b1; d = '0; u = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         if (done) begin
            ndone++;
            if (lat < 0) begin lat = c; d = diff; u = underflow; end
         end else if (lat < 0 && (diff !== '0 || underflow !== 1'b0)) begin
            held_ok = 1'b0;
         end
         @(posedge clk); #1;
         start = 1'b0;
         a = NB'($urandom); b = NB'($urandom);
      end
      checks++;
      if (ndone != 1 || lat != NB) begin
         errors++;
         $display("FAIL ignore_start_count: dones=%0d latency=%0d required 1 %0d", ndone, lat, NB);
      end
      checks++;
      if ({u, d} !== ref_sub(12, 5, 0)) begin
         errors++;
         $display("FAIL ignore_start_result: got uf=%b diff=%h required uf=0 diff=7", u, d);
      end
      checks++;
      if (!held_ok) begin
         errors++;
         $display("FAIL ignore_start_hold: diff/underflow changed before done, required held at 0");
      end
   endtask

   task automatic test_reset_mid_op();
      int ndone, lat, bcnt; bit ovl; logic [NB-1:0] d; logic u;
      a = 4'd10; b = 4'd4; borrow_in = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      n_rst = 1'b0;
      @(posedge clk); #1;
      n_rst = 1'b1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || underflow !== 1'b0) begin
         errors++;
         $display("FAIL midreset_clear: busy=%b done=%b diff=%h uf=%b required 0 0 0 0",
                  busy, done, diff, underflow);
      end
      ndone = 0;
      for (int c = 0; c < 8; c++) begin
         if (done || busy) ndone++;
         @(posedge clk); #1;
      end
      checks++;
      if (ndone != 0) begin
         errors++;
         $display("FAIL midreset_nodone: active cycles=%0d required 0", ndone);
      end
      do_op(10, 4, 0, lat, bcnt, ovl, d, u);
      checks++;
      if ({u, d} !== ref_sub(10, 4, 0) || lat != NB) begin
         errors++;
         $display("FAIL midreset_rerun: got uf=%b diff=%h latency=%0d required uf=0 diff=6 latency=%0d",
                  u, d, lat, NB);
      end
   endtask

   task automatic test_exhaustive();
      int order[512];
      int lat, bcnt; bit ovl; logic [NB-1:0] d; logic u;
      logic [NB:0] e;
      int j, t, av, bv, bi;
      for (int i = 0; i < 512; i++) order[i] = i;
      for (int i = 511; i > 0; i--) begin
         j = $urandom_range(i, 0);
         t = order[i]; order[i] = order[j]; order[j] = t;
      end
      for (int i = 0; i < 512; i++) begin
         av = order[i] & 15; bv = (order[i] >> 4) & 15; bi = (order[i] >> 8) & 1;
         exp_q.push_back(ref_sub(av, bv, bi));
         do_op(av, bv, bi, lat, bcnt, ovl, d, u);
         e = exp_q.pop_front();
         checks++;
         if ({u, d} !== e || lat != NB || ovl) begin
            errors++;
            $display("FAIL exhaustive %0d-%0d-%0d: got uf=%b diff=%h lat=%0d ovl=%b required uf=%b diff=%h lat=%0d",
                     av, bv, bi, u, d, lat, ovl, e[NB], e[NB-1:0], NB);
         end
         // Random idle gap; zero gap exercises back-to-back starts.
         repeat ($urandom_range(2, 0)) begin
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_wide();
      int lat;
      int av, bv, bi, r;
      logic [NB8-1:0] ed; logic eu;
      for (int i = 0; i < 6; i++) begin
         if (i == 0) begin av = 0; bv = 1; bi = 0; end
         else begin av = $urandom_range(255, 0); bv = $urandom_range(255, 0); bi = $urandom_range(1, 0); end
         r = av - bv - bi;
         ed = NB8'(r & 255); eu = (av < bv + bi);
         a8 = NB8'(av); b8 = NB8'(bv); borrow_in8 = bi[0]; start8 = 1'b1;
         @(posedge clk); #1;
         start8 = 1'b0;
         lat = -1;
         for (int c = 0; c <= NB8 + 6; c++) begin
            if (done8) begin lat = c; break; end
            @(posedge clk); #1;
         end
         checks++;
         if (lat != NB8 || diff8 !== ed || underflow8 !== eu) begin
            errors++;
            $display("FAIL wide %0d-%0d-%0d: got diff=%h uf=%b lat=%0d required diff=%h uf=%b lat=%0d",
                     av, bv, bi, diff8, underflow8, lat, ed, eu, NB8);
         end
         @(posedge clk); #1;
      end
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_start_ignored();
      test_reset_mid_op();
      test_exhaustive();
      test_wide();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_subtractor_nbit.md
# serial_subtractor_nbit

Bit-serial N-bit subtractor computing a − b − borrow_in one bit per clock, LSB first, with a start/done handshake. It is the inverse arithmetic counterpart of the combinational adder_nbit datapath. It is for contexts where area matters more than latency, and it returns the same result format: an N-bit result plus one status bit (underflow in place of overflow). It sits between a requesting controller and any consumer of the registered result.

## Interface
- NUM_BITS, default 4, operand and result width (≥ 2)
- clk  input  1  system clock, all logic on rising edge
- n_rst  input  1  synchronous, active-low reset, sampled on rising edge of clk
- start  input  1  request; sampled only in IDLE or DONE
- a  input  NUM_BITS  minuend, captured on accepted start
- b  input  NUM_BITS  subtrahend, captured on accepted start
- borrow_in  input  1  borrow into bit 0, captured on accepted start
- busy  output  1  high while in SHIFT
- done  output  1  one-cycle pulse: result valid and updated
- diff  output  NUM_BITS  registered result, (a − b − borrow_in) mod 2^NUM_BITS
- underflow  output  1  registered final borrow; 1 iff a < b + borrow_in (unsigned)

## Operation
- State machine: IDLE, SHIFT, DONE.
  - IDLE: start=1 → latch a, b, borrow_in into operand shift registers and running borrow; clear bit counter; go to SHIFT. start=0 → stay.
  - SHIFT: each cycle processes bit k = counter.
    - d = a_k ^ b_k ^ br
    - br' = (~a_k & b_k) | (~(a_k ^ b_k) & br)
    - d shifts into the MSB of the internal result register, which shifts right.
    - Counter increments. After the cycle processing bit NUM_BITS−1, go to DONE and load diff/underflow from the internal result register and final borrow.
  - DONE: done=1 for exactly this cycle. start=1 → capture new operands and go to SHIFT (back-to-back). Otherwise go to IDLE.
- start in SHIFT is ignored; no queuing, and operands may change freely while busy.
- diff and underflow change only on the edge entering DONE, and hold until the next such edge. Intermediate shift values never appear on them.
- Counter width: clog2(NUM_BITS)+1 bits. No wrap inside an operation.
- Reset (n_rst=0 at an edge), including mid-SHIFT: state → IDLE, counter/shift registers/borrow cleared, busy=0, done=0, diff=0, underflow=0. The aborted operation produces no done.

## Timing
- Reset values: busy=0, done=0, diff=0, underflow=0.
- start accepted at edge E0 → busy=1 after E0 through edge E_NUM_BITS.
- SHIFT lasts exactly NUM_BITS cycles; done=1 and new diff/underflow are visible after edge E_NUM_BITS.
- Latency start-accept to done: NUM_BITS cycles.
- Throughput with start held high: one result per NUM_BITS+1 cycles.
- busy and done are never high together.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset then 7−3, borrow_in=0, NUM_BITS=4 → done exactly 4 cycles after accept; diff=4, underflow=0; busy high for 4 cycles.
- 3−7, borrow_in=0 → diff=12 (0xC), underflow=1. Then 0−0, borrow_in=1 → diff=15, underflow=1.
- 15−15, borrow_in=0 → diff=0, underflow=0. start held high in its DONE cycle with 9−2, borrow_in=1 → second done 5 cycles after the first; diff=6, underflow=0.
- Operation 12−5 running; pulse start with 1−1 and change a/b at SHIFT cycle 2 → exactly one done; diff=7, underflow=0; diff stays 0 (previous value) until that done.
- n_rst=0 for one edge at SHIFT cycle 2 of 10−4 → next cycle busy=0, diff=0, underflow=0; no done for 8 further cycles. Then 10−4 again → diff=6.
- Exhaustive: all 512 (a, b, borrow_in) combinations at NUM_BITS=4 → diff == (a−b−borrow_in) mod 16 and underflow == (a < b+borrow_in) on every done. Also a NUM_BITS=8 spot check: 0x00−0x01 → diff=0xFF, underflow=1, done after 8 cycles.
